// File: rtl/fpadd_pipe.sv
// Three-stage elastic floating-point adder/subtractor (align, add, normalise/round/pack).
// Define FPADD_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fpadd_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic                 ctrl,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] ans,
   output logic                 ovf,
   output logic                 unf
);

   localparam int W   = EXP_W + MAN_W + 1;
   localparam int SW  = MAN_W + 4;
   localparam int LZW = $clog2(MAN_W + 4);
   localparam int XW  = EXP_W + LZW + 2;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
      logic [LZW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < SW; i++)
         if (v[i]) cnt = LZW'(SW - 1 - i);
      return cnt;
   endfunction

   // handshake: each stage loads when empty or when its occupant moves on this edge
   logic v1, v2, v3;
   logic ld1, ld2, ld3;

   assign ld3       = ~v3 | out_ready;
   assign ld2       = ~v2 | ld3;
   assign ld1       = ~v1 | ld2;
   assign in_ready  = ld1;
   assign out_valid = v3;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (ld1) v1 <= in_valid;
         if (ld2) v2 <= v1;
         if (ld3) v3 <= v2;
      end
   end

   // stage 1: classify, swap, align
   logic             sa, sb, ia, ib, a_big;
   logic [EXP_W-1:0] ea, eb, big_exp, sml_exp, exp_diff;
   logic [MAN_W:0]   sig_a, sig_b, big_sig, sml_sig;
   logic             big_sign, lost, spec_d;
   logic [SW-1:0]    sml_ext, sml_sh, sml_aln;
   logic [W-1:0]     spec_ans_d;

   always_comb begin
      sa       = a[W-1];
      sb       = b[W-1] ^ ctrl;
      ea       = a[W-2:MAN_W];
      eb       = b[W-2:MAN_W];
      ia       = (ea == EXP_ONES);
      ib       = (eb == EXP_ONES);
      sig_a    = (ea == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
      sig_b    = (eb == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
      a_big    = (a[W-2:0] >= b[W-2:0]);
      big_sign = a_big ? sa : sb;
      big_exp  = a_big ? ea : eb;
      big_sig  = a_big ? sig_a : sig_b;
      sml_exp  = a_big ? eb : ea;
      sml_sig  = a_big ? sig_b : sig_a;
      exp_diff = big_exp - sml_exp;
      sml_ext  = {sml_sig, 3'b000};
      sml_sh   = sml_ext >> exp_diff;
      lost     = |(sml_ext & ~({SW{1'b1}} << exp_diff));
      if (int'(exp_diff) >= MAN_W + 3)
         sml_aln = {{(SW-1){1'b0}}, |sml_sig};
      else
         sml_aln = {sml_sh[SW-1:1], sml_sh[0] | lost};
      spec_d = ia | ib;
      if (ia && ib && (sa != sb))
         spec_ans_d = QNAN;
      else if (ia)
         spec_ans_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
      else
         spec_ans_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
   end

   logic             s1_sign, s1_sub, s1_spec;
   logic [EXP_W-1:0] s1_exp;
   logic [MAN_W:0]   s1_sig_big;
   logic [SW-1:0]    s1_sig_sml;
   logic [W-1:0]     s1_spec_ans;

   always_ff @(posedge clk) begin
      if (ld1 && in_valid) begin
         s1_sign     <= big_sign;
         s1_sub      <= sa ^ sb;
         s1_exp      <= big_exp;
         s1_sig_big  <= big_sig;
         s1_sig_sml  <= sml_aln;
         s1_spec     <= spec_d;
         s1_spec_ans <= spec_ans_d;
      end
   end

   // stage 2: magnitude add or subtract (big is never smaller than small)
   logic [MAN_W+4:0] sum_d;

   always_comb begin
      if (s1_sub)
         sum_d = {1'b0, s1_sig_big, 3'b000} - {1'b0, s1_sig_sml};
      else
         sum_d = {1'b0, s1_sig_big, 3'b000} + {1'b0, s1_sig_sml};
   end

   logic             s2_sign, s2_spec;
   logic [EXP_W-1:0] s2_exp;
   logic [MAN_W+4:0] s2_sum;
   logic [W-1:0]     s2_spec_ans;

   always_ff @(posedge clk) begin
      if (ld2 && v1) begin
         s2_sign     <= s1_sign;
         s2_exp      <= s1_exp;
         s2_sum      <= sum_d;
         s2_spec     <= s1_spec;
         s2_spec_ans <= s1_spec_ans;
      end
   end

   // stage 3: normalise, round, pack, special cases
   logic [LZW-1:0]   lz;
   logic [SW-1:0]    norm;
   logic [XW-1:0]    e_n;
   logic [MAN_W-1:0] frac;
   logic [W-1:0]     ans_d;
   logic             ovf_d, unf_d;
`ifdef FPADD_RNE_EN
   logic             rnd_inc;
   logic [MAN_W+1:0] man_r;
`else
   logic             grs_unused;
   assign grs_unused = |{norm[SW-1], norm[2:0]};
`endif

   always_comb begin
      lz    = '0;
      norm  = '0;
      e_n   = '0;
      frac  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
`ifdef FPADD_RNE_EN
      rnd_inc = 1'b0;
      man_r   = '0;
`endif
      if (s2_sum[MAN_W+4]) begin
         norm = {s2_sum[MAN_W+4:2], s2_sum[1] | s2_sum[0]};
         e_n  = XW'(s2_exp) + XW'(1);
      end else begin
         lz   = lzc(s2_sum[SW-1:0]);
         norm = s2_sum[SW-1:0] << lz;
         e_n  = XW'(s2_exp) - XW'(lz);
      end
`ifdef FPADD_RNE_EN
      rnd_inc = norm[2] & (norm[1] | norm[0] | norm[3]);
      man_r   = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rnd_inc);
      if (man_r[MAN_W+1]) begin
         frac = man_r[MAN_W:1];
         e_n  = e_n + XW'(1);
      end else begin
         frac = man_r[MAN_W-1:0];
      end
`else
      frac = norm[SW-2:3];
`endif
      ans_d = {s2_sign, e_n[EXP_W-1:0], frac};
      if (s2_spec) begin
         ans_d = s2_spec_ans;
      end else if (s2_sum == '0) begin
         ans_d = '0;
      end else if (!e_n[XW-1] && (e_n >= XW'(EXP_ONES))) begin
         ans_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
         ovf_d = 1'b1;
      end else if (e_n[XW-1] || (e_n == '0)) begin
         ans_d = {s2_sign, {(W-1){1'b0}}};
         unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ans <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (ld3 && v2) begin
         ans <= ans_d;
         ovf <= ovf_d;
         unf <= unf_d;
      end
   end

endmodule
